ff_assoc_cache: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate flip-flop cache; successor to the direct-mapped FF cache.

---
 rtl/ff_assoc_cache_pkg.sv | 17 +
 rtl/ff_cache_plru.sv | 38 +++
 rtl/ff_assoc_cache.sv | 186 ++++++++++++++++++
 tb/tb_ff_assoc_cache.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_assoc_cache_pkg.sv
// Shared types for the set-associative flip-flop cache: controller states and the 256-bit line.
package ff_assoc_cache_pkg;

    localparam int DEF_S_OFFSET = 5;
    localparam int LINE_BITS    = 256;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_FILL,
        ST_FLUSH_SCAN,
        ST_FLUSH_WB
    } cache_state_t;

endpackage

// File: rtl/ff_cache_plru.sv
// Tree pseudo-LRU for one set: derives the victim way and the tree after touching access_way_i.
module ff_cache_plru #(
    parameter  int WAYS = 2,
    localparam int LVL  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int TW   = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [TW-1:0]  tree_i,
    input  logic [LVL-1:0] access_way_i,
    output logic [TW-1:0]  tree_o,
    output logic [LVL-1:0] victim_o
);

    if (WAYS == 1) begin : g_direct
        assign tree_o   = tree_i;
        assign victim_o = '0;
    end else begin : g_tree
        localparam int NW = (TW > 1) ? $clog2(TW) : 1;
        logic [NW-1:0] node;

        // Heap-ordered tree: children of node n are 2n+1 (bit 0, lower half) and 2n+2.
        always_comb begin
            // NOTE: every output gets a default before any branch so no latch is inferred.
            tree_o   = tree_i;
            victim_o = '0;
            node     = '0;
            for (int l = 0; l < LVL; l++) begin
                victim_o[LVL-1-l] = tree_i[node];
                node = NW'((int'(node) << 1) + 1 + int'(tree_i[node]));
            end
            node = '0;
            for (int l = 0; l < LVL; l++) begin
                tree_o[node] = ~access_way_i[LVL-1-l];
                node = NW'((int'(node) << 1) + 1 + int'(access_way_i[LVL-1-l]));
            end
        end
    end

endmodule

// File: rtl/ff_assoc_cache.sv
// N-way set-associative write-back, write-allocate cache held in flip-flops, with full-cache flush.
module ff_assoc_cache
    import ff_assoc_cache_pkg::*;
#(
    parameter int S_OFFSET = DEF_S_OFFSET,
    parameter int S_INDEX  = 3,
    parameter int WAYS     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_byte_enable,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    input  logic         flush_req,
    output logic         flush_done,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic [255:0] pmem_rdata,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp
);

    localparam int S_TAG = 32 - S_OFFSET - S_INDEX;
    localparam int SETS  = 2 ** S_INDEX;
    localparam int WL    = $clog2(WAYS);
    localparam int WW    = (WAYS > 1) ? WL : 1;
    localparam int TW    = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int CW    = S_INDEX + WL;

    line_t            data_q  [SETS][WAYS];
    logic [S_TAG-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [TW-1:0]    plru_q  [SETS];

    cache_state_t  state_q, state_d;
    logic [WW-1:0] victim_q, victim_d;
    logic [CW:0]   cnt_q, cnt_d;

    logic [S_TAG-1:0]   tag;
    logic [S_INDEX-1:0] idx, fset;
    logic [WW-1:0]      fway, hit_way, miss_way, plru_victim, access_way;
    logic [TW-1:0]      plru_next;
    logic               hit, inv_found, req;
    logic               unused_offset;

    assign tag           = mem_address[31 -: S_TAG];
    assign idx           = mem_address[S_OFFSET +: S_INDEX];
    assign unused_offset = ^mem_address[S_OFFSET-1:0];
    assign req           = mem_read | mem_write;
    // The flush counter is {set,way}; its extra top bit marks "all entries visited".
    assign fset          = S_INDEX'(cnt_q >> WL);
    assign fway          = WW'(cnt_q & (CW+1)'(WAYS - 1));
    assign access_way    = (state_q == ST_FILL) ? victim_q : hit_way;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        miss_way  = plru_victim;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag && !hit) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                miss_way  = WW'(w);
            end
        end
    end

    ff_cache_plru #(.WAYS(WAYS)) u_plru (
        .tree_i       (plru_q[idx]),
        .access_way_i (access_way),
        .tree_o       (plru_next),
        .victim_o     (plru_victim)
    );

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!hit) begin
                        victim_d = miss_way;
                        state_d  = (valid_q[idx][miss_way] && dirty_q[idx][miss_way])
                                   ? ST_WRITEBACK : ST_FILL;
                    end
                end else if (flush_req) begin
                    cnt_d   = '0;
                    state_d = ST_FLUSH_SCAN;
                end
            end
            ST_WRITEBACK: if (pmem_resp) state_d = ST_FILL;
            ST_FILL:      if (pmem_resp) state_d = ST_IDLE;
            ST_FLUSH_SCAN: begin
                if (cnt_q[CW])
                    state_d = ST_IDLE;
                else if (valid_q[fset][fway] && dirty_q[fset][fway])
                    state_d = ST_FLUSH_WB;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            ST_FLUSH_WB: begin
                if (pmem_resp) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_FLUSH_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            victim_q <= '0;
            cnt_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            cnt_q    <= cnt_d;
            if (state_q == ST_IDLE && req && hit) begin
                plru_q[idx] <= plru_next;
                if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (state_q == ST_WRITEBACK && pmem_resp) dirty_q[idx][victim_q] <= 1'b0;
            if (state_q == ST_FLUSH_WB && pmem_resp)  dirty_q[fset][fway] <= 1'b0;
            if (state_q == ST_FILL && pmem_resp) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
                plru_q[idx]            <= plru_next;
            end
        end
    end

    // NOTE: data and tag arrays carry no reset; valid bits alone decide whether their contents count.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && mem_write && hit) begin
            for (int b = 0; b < 32; b++)
                if (mem_byte_enable[b]) data_q[idx][hit_way][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (state_q == ST_FILL && pmem_resp) begin
            data_q[idx][victim_q] <= pmem_rdata;
            tag_q[idx][victim_q]  <= tag;
        end
    end

    assign mem_resp   = (state_q == ST_IDLE) && req && hit;
    assign mem_rdata  = data_q[idx][hit_way];
    assign flush_done = (state_q == ST_FLUSH_SCAN) && cnt_q[CW];
    assign pmem_read  = (state_q == ST_FILL);
    assign pmem_write = (state_q == ST_WRITEBACK) || (state_q == ST_FLUSH_WB);

    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state_q)
            ST_WRITEBACK: begin
                pmem_address = {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}};
                pmem_wdata   = data_q[idx][victim_q];
            end
            ST_FILL:     pmem_address = {tag, idx, {S_OFFSET{1'b0}}};
            ST_FLUSH_WB: begin
                pmem_address = {tag_q[fset][fway], fset, {S_OFFSET{1'b0}}};
                pmem_wdata   = data_q[fset][fway];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ff_assoc_cache.sv
// Directed bench for ff_assoc_cache (WAYS=2, S_INDEX=3) with a fixed-latency line memory.
module tb_ff_assoc_cache;
    import ff_assoc_cache_pkg::*;

    localparam int    LAT  = 2;
    localparam line_t D040 = {8{32'h1111_0040}};
    localparam line_t D140 = {8{32'h2222_0140}};
    localparam line_t D240 = {8{32'h3333_0240}};
    localparam line_t D340 = {8{32'h6666_0340}};
    localparam line_t D020 = {8{32'h4444_0020}};
    localparam line_t D0E0 = {8{32'h5555_00E0}};
    localparam line_t W040 = {{7{32'hDEAD_BEEF}}, 32'hAABB_CCDD};
    localparam line_t M040 = {{7{32'h1111_0040}}, 32'hAABB_CCDD};
    localparam line_t W020 = {8{32'h7777_0020}};
    localparam line_t W0E0 = {8{32'h8888_00E0}};
    localparam line_t M0E0 = {{6{32'h5555_00E0}}, 32'h8888_00E0, 32'h5555_00E0};

    logic         clk, rst;
    logic [31:0]  mem_address, mem_byte_enable, pmem_address;
    logic         mem_read, mem_write, mem_resp, flush_req, flush_done;
    logic         pmem_read, pmem_write, pmem_resp;
    line_t        mem_wdata, mem_rdata, pmem_rdata, pmem_wdata;

    line_t        mem_lines [64];
    logic         log_wr    [16];
    logic [31:0]  log_addr  [16];
    line_t        log_data  [16];
    int           log_n, both_err, checks, errors;

    ff_assoc_cache #(.S_INDEX(3), .WAYS(2)) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .flush_req(flush_req), .flush_done(flush_done),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag, input int i, input logic wr,
                             input logic [31:0] a, input line_t d);
        check({tag, "_op"}, 256'({log_wr[i], log_addr[i]}), 256'({wr, a}));
        check({tag, "_data"}, log_data[i], d);
    endtask

    // Memory: responds LAT cycles after a request appears, logs every completed transfer.
    initial begin
        int wcnt;
        wcnt = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_read && pmem_write) both_err++;
            if (rst || pmem_resp) begin
                pmem_resp = 1'b0;
                wcnt = 0;
            end else if (pmem_read || pmem_write) begin
                wcnt++;
                if (wcnt == LAT) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) mem_lines[pmem_address[10:5]] = pmem_wdata;
                    else            pmem_rdata = mem_lines[pmem_address[10:5]];
                    if (log_n < 16) begin
                        log_wr[log_n]   = pmem_write;
                        log_addr[log_n] = pmem_address;
                        log_data[log_n] = pmem_write ? pmem_wdata : pmem_rdata;
                    end
                    log_n++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic cpu_access(input string tag, input logic wr, input logic [31:0] addr,
                              input logic [31:0] be, input line_t wd,
                              output line_t rd, output int cyc);
        @(negedge clk);
        mem_address = addr;
        mem_read = !wr;
        mem_write = wr;
        mem_byte_enable = be;
        mem_wdata = wd;
        cyc = 0;
        #1;
        while (!mem_resp && cyc < 40) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        if (!mem_resp) check({tag, "_resp_timeout"}, 256'(mem_resp), 256'(1));
        rd = mem_rdata;
        @(negedge clk);
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wait_flush_done(output int cyc);
        cyc = 0;
        #1;
        while (!flush_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            #1;
        end
    endtask

    initial begin
        line_t rd;
        int    cyc, n0;
        checks = 0; errors = 0; log_n = 0; both_err = 0;
        rst = 1'b1;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0; flush_req = 1'b0;
        for (int i = 0; i < 64; i++) mem_lines[i] = '0;
        mem_lines[2]  = D040;
        mem_lines[10] = D140;
        mem_lines[18] = D240;
        mem_lines[26] = D340;
        mem_lines[1]  = D020;
        mem_lines[7]  = D0E0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_resp", 256'(mem_resp), 256'(0));
        check("rst_flush_done", 256'(flush_done), 256'(0));
        check("rst_pmem_rw", 256'({pmem_read, pmem_write}), 256'(0));
        check("rst_pmem_addr", 256'(pmem_address), 256'(0));
        rst = 1'b0;

        // Cold read miss, then hit.
        cpu_access("rd40_miss", 1'b0, 32'h40, '0, '0, rd, cyc);
        check("rd40_miss_data", rd, D040);
        check("rd40_miss_cyc", 256'(cyc), 256'(3));
        check_log("log0", 0, 1'b0, 32'h40, D040);
        cpu_access("rd40_hit", 1'b0, 32'h40, '0, '0, rd, cyc);
        check("rd40_hit_data", rd, D040);
        check("rd40_hit_cyc", 256'(cyc), 256'(0));
        check("rd40_hit_nopmem", 256'(log_n), 256'(1));

        // Byte-enabled write hit.
        cpu_access("wr40", 1'b1, 32'h40, 32'h0000_000F, W040, rd, cyc);
        check("wr40_cyc", 256'(cyc), 256'(0));
        cpu_access("rd40_merged", 1'b0, 32'h40, '0, '0, rd, cyc);
        check("rd40_merged_data", rd, M040);

        // Set 2 conflict: second way fills, third line evicts dirty 0x40 chosen by PLRU.
        cpu_access("rd140", 1'b0, 32'h140, '0, '0, rd, cyc);
        check("rd140_data", rd, D140);
        check_log("log1", 1, 1'b0, 32'h140, D140);
        cpu_access("rd240", 1'b0, 32'h240, '0, '0, rd, cyc);
        check("rd240_data", rd, D240);
        check_log("log2", 2, 1'b1, 32'h040, M040);
        check_log("log3", 3, 1'b0, 32'h240, D240);
        cpu_access("rd140_hit", 1'b0, 32'h140, '0, '0, rd, cyc);
        check("rd140_hit_data", rd, D140);
        check("rd140_hit_cyc", 256'(cyc), 256'(0));
        check("rd140_hit_nopmem", 256'(log_n), 256'(4));

        // Two dirty lines via write-allocate, then flush.
        cpu_access("wr020", 1'b1, 32'h020, 32'hFFFF_FFFF, W020, rd, cyc);
        cpu_access("wr0e0", 1'b1, 32'h0E0, 32'h0000_00F0, W0E0, rd, cyc);
        check_log("log4", 4, 1'b0, 32'h020, D020);
        check_log("log5", 5, 1'b0, 32'h0E0, D0E0);
        @(negedge clk);
        flush_req = 1'b1;
        wait_flush_done(cyc);
        check("flush_done_seen", 256'(flush_done), 256'(1));
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        check("flush_done_pulse", 256'(flush_done), 256'(0));
        check_log("log6", 6, 1'b1, 32'h020, W020);
        check_log("log7", 7, 1'b1, 32'h0E0, M0E0);
        cpu_access("rd020_after_flush", 1'b0, 32'h020, '0, '0, rd, cyc);
        check("rd020_after_flush_data", rd, W020);
        check("rd020_after_flush_cyc", 256'(cyc), 256'(0));
        cpu_access("rd0e0_after_flush", 1'b0, 32'h0E0, '0, '0, rd, cyc);
        check("rd0e0_after_flush_data", rd, M0E0);
        check("rd0e0_after_flush_cyc", 256'(cyc), 256'(0));
        check("flush_log_count", 256'(log_n), 256'(8));

        // Refetch 0x40 (gets the written-back line), then race a hit against flush_req.
        cpu_access("rd40_refill", 1'b0, 32'h40, '0, '0, rd, cyc);
        check("rd40_refill_data", rd, M040);
        check_log("log8", 8, 1'b0, 32'h040, M040);
        @(negedge clk);
        mem_address = 32'h40;
        mem_read = 1'b1;
        flush_req = 1'b1;
        #1;
        check("race_mem_resp", 256'(mem_resp), 256'(1));
        check("race_rdata", mem_rdata, M040);
        check("race_no_flush_done", 256'(flush_done), 256'(0));
        @(negedge clk);
        mem_read = 1'b0;
        wait_flush_done(cyc);
        check("race_flush_cyc", 256'(cyc), 256'(17));
        @(negedge clk);
        flush_req = 1'b0;
        check("race_log_count", 256'(log_n), 256'(9));

        // Reset while a fill is outstanding.
        @(negedge clk);
        mem_address = 32'h340;
        mem_read = 1'b1;
        @(negedge clk);
        #1;
        check("rstfill_pmem_read", 256'(pmem_read), 256'(1));
        check("rstfill_pmem_addr", 256'(pmem_address), 256'(32'h340));
        rst = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        check("rstfill_pmem_rw", 256'({pmem_read, pmem_write}), 256'(0));
        check("rstfill_pmem_addr0", 256'(pmem_address), 256'(0));
        rst = 1'b0;
        n0 = log_n;
        check("rstfill_abandoned", 256'(n0), 256'(9));
        cpu_access("rd40_after_rst", 1'b0, 32'h40, '0, '0, rd, cyc);
        check("rd40_after_rst_data", rd, M040);
        check("rd40_after_rst_cyc", 256'(cyc), 256'(3));
        check_log("log9", 9, 1'b0, 32'h040, M040);

        check("pmem_rw_exclusive", 256'(both_err), 256'(0));
        check("final_log_count", 256'(log_n), 256'(10));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
